// File: rtl/bcd_scan_driver.sv
// Three-digit multiplexed seven-segment driver for a packed BCD word.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module bcd_scan_driver #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] bcd_in,
  input  logic        load,
  output logic [6:0]  seg_n,
  output logic [2:0]  dig_en_n,
  output logic        err,
  output logic        frame
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    DIG_ONES  = 2'd0,
    DIG_TENS  = 2'd1,
    DIG_HUNDS = 2'd2
  } dig_e;

  // Active-low g..a pattern; any non-decimal nibble shows a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'b1000000;
      4'd1:    pat = 7'b1111001;
      4'd2:    pat = 7'b0100100;
      4'd3:    pat = 7'b0110000;
      4'd4:    pat = 7'b0011001;
      4'd5:    pat = 7'b0010010;
      4'd6:    pat = 7'b0000010;
      4'd7:    pat = 7'b1111000;
      4'd8:    pat = 7'b0000000;
      4'd9:    pat = 7'b0010000;
      default: pat = 7'b0111111;
    endcase
    return pat;
  endfunction

  function automatic logic any_invalid(input logic [11:0] word);
    return (word[11:8] > 4'd9) || (word[7:4] > 4'd9) || (word[3:0] > 4'd9);
  endfunction

  logic [11:0]   held_r;
  logic [CW-1:0] cnt_r;
  dig_e          idx_r;
  dig_e          idx_next_s;
  logic          wrap_s;
  logic [3:0]    nib_s;
  logic          blank_s;
  logic [6:0]    seg_next_s;
  logic [2:0]    dig_next_s;

  assign wrap_s = (cnt_r == CNT_MAX);

  // Digit-select state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_r <= DIG_ONES;
    end else begin
      idx_r <= idx_next_s;
    end
  end

  // Next digit and per-digit output decode from the current selection.
  always_comb begin
    idx_next_s = idx_r;
    nib_s      = held_r[3:0];
    dig_next_s = 3'b111;
    if (wrap_s) begin
      case (idx_r)
        DIG_ONES:  idx_next_s = DIG_TENS;
        DIG_TENS:  idx_next_s = DIG_HUNDS;
        DIG_HUNDS: idx_next_s = DIG_ONES;
        default:   idx_next_s = DIG_ONES;
      endcase
    end else begin
      idx_next_s = idx_r;
    end
    case (idx_r)
      DIG_ONES: begin
        nib_s      = held_r[3:0];
        dig_next_s = 3'b110;
      end
      DIG_TENS: begin
        nib_s      = held_r[7:4];
        dig_next_s = 3'b101;
      end
      DIG_HUNDS: begin
        nib_s      = held_r[11:8];
        dig_next_s = 3'b011;
      end
      default: begin
        nib_s      = held_r[3:0];
        dig_next_s = 3'b111;
      end
    endcase
  end

  // Blanking only ever hits zero nibbles, so an out-of-range digit still shows its dash.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    blank_s = ((idx_r == DIG_HUNDS) && (held_r[11:8] == 4'd0)) ||
              ((idx_r == DIG_TENS) && (held_r[11:8] == 4'd0) && (held_r[7:4] == 4'd0));
`else
    blank_s = 1'b0;
`endif
    if (blank_s) begin
      seg_next_s = 7'h7F;
    end else begin
      seg_next_s = seg_decode(nib_s);
    end
  end

  // Held word, prescaler and registered display outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      held_r   <= 12'h000;
      cnt_r    <= '0;
      seg_n    <= 7'h7F;
      dig_en_n <= 3'b111;
      err      <= 1'b0;
      frame    <= 1'b0;
    end else begin
      if (load) begin
        held_r <= bcd_in;
      end
      cnt_r    <= wrap_s ? '0 : cnt_r + {{(CW-1){1'b0}}, 1'b1};
      seg_n    <= seg_next_s;
      dig_en_n <= dig_next_s;
      err      <= any_invalid(held_r);
      frame    <= wrap_s && (idx_r == DIG_HUNDS);
    end
  end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Directed self-checking bench for bcd_scan_driver with PRESCALE=4.
module tb_bcd_scan_driver;

  logic        clk;
  logic        reset;
  logic [11:0] bcd_in;
  logic        load;
  logic [6:0]  seg_n;
  logic [2:0]  dig_en_n;
  logic        err;
  logic        frame;

  int compared;
  int mismatched;

  logic [11:0] m_held;
  int          m_cnt;
  int          m_idx;
  int          frames;

  bcd_scan_driver #(.PRESCALE(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .bcd_in   (bcd_in),
    .load     (load),
    .seg_n    (seg_n),
    .dig_en_n (dig_en_n),
    .err      (err),
    .frame    (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock edge; expected outputs come from the pre-edge model state.
  task automatic tick(input string tag);
    logic [3:0]  nib;
    logic [6:0]  e_seg;
    logic [2:0]  e_dig;
    logic        e_err;
    logic        e_frame;
    if (reset) begin
      e_seg = 7'h7F; e_dig = 3'b111; e_err = 1'b0; e_frame = 1'b0;
    end else begin
      nib   = (m_idx == 0) ? m_held[3:0] : (m_idx == 1) ? m_held[7:4] : m_held[11:8];
      e_seg = pat(nib);
`ifdef LEADING_ZERO_BLANK_EN
      if (m_idx == 2 && m_held[11:8] == 4'd0) e_seg = 7'h7F;
      if (m_idx == 1 && m_held[11:8] == 4'd0 && m_held[7:4] == 4'd0) e_seg = 7'h7F;
`endif
      e_dig   = (m_idx == 0) ? 3'b110 : (m_idx == 1) ? 3'b101 : 3'b011;
      e_err   = (m_held[11:8] > 4'd9) || (m_held[7:4] > 4'd9) || (m_held[3:0] > 4'd9);
      e_frame = (m_cnt == 3) && (m_idx == 2);
    end
    @(posedge clk);
    #1;
    if (reset) begin
      m_held = 12'h000; m_cnt = 0; m_idx = 0;
    end else begin
      if (load) m_held = bcd_in;
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_idx = (m_idx == 2) ? 0 : m_idx + 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    chk(tag, {seg_n, dig_en_n, err, frame}, {e_seg, e_dig, e_err, e_frame});
  endtask

  initial begin
    compared = 0; mismatched = 0; frames = 0;
    m_held = 12'h000; m_cnt = 0; m_idx = 0;
    reset = 1'b1; load = 1'b0; bcd_in = 12'h000;

    for (int i = 0; i < 3; i++) tick("reset_hold");
    chk("reset_lit", {seg_n, dig_en_n, err, frame}, {7'h7F, 3'b111, 1'b0, 1'b0});

    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick("scan_zero");

    // 12'h123 loaded, then two whole frames counted for frame pulses
    bcd_in = 12'h123; load = 1'b1;
    tick("load_123");
    load = 1'b0;
    for (int i = 0; i < 3; i++) tick("ones_123");
    chk("ones_3_lit", {seg_n, dig_en_n}, {2'b00, 7'h30, 3'b110});
    for (int i = 0; i < 4; i++) tick("tens_123");
    chk("tens_2_lit", {seg_n, dig_en_n}, {2'b00, 7'h24, 3'b101});
    for (int i = 0; i < 4; i++) tick("hund_123");
    chk("hund_1_lit", {seg_n, dig_en_n, frame}, {1'b0, 7'h79, 3'b011, 1'b1});
    for (int i = 0; i < 12; i++) begin
      tick("frame_123");
      if (frame) frames++;
    end
    chk("frame_count", 12'(frames), 12'd1);

    bcd_in = 12'h007; load = 1'b1;
    tick("load_007");
    load = 1'b0;
    for (int i = 0; i < 11; i++) tick("scan_007");
    chk("hund_007_lit", {seg_n, dig_en_n},
`ifdef LEADING_ZERO_BLANK_EN
        {2'b00, 7'h7F, 3'b011});
`else
        {2'b00, 7'h40, 3'b011});
`endif

    bcd_in = 12'h1A5; load = 1'b1;
    tick("load_1a5");
    load = 1'b0;
    tick("err_1a5");
    chk("err_set_lit", 12'(err), 12'd1);
    for (int i = 0; i < 12; i++) tick("scan_1a5");
    bcd_in = 12'h105; load = 1'b1;
    tick("load_105");
    load = 1'b0;
    tick("err_105");
    chk("err_clr_lit", 12'(err), 12'd0);

    for (int i = 0; i < 16 && !(m_idx == 2 && m_cnt == 2); i++) tick("seek_mid");
    chk("seek_mid_ok", 12'((m_idx == 2 && m_cnt == 2) ? 1 : 0), 12'd1);
    reset = 1'b1;
    tick("reset_mid");
    chk("reset_mid_lit", {seg_n, dig_en_n, err, frame}, {7'h7F, 3'b111, 1'b0, 1'b0});
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick("restart_dwell");
      chk("restart_lit", {seg_n, dig_en_n}, {2'b00, 7'h40, 3'b110});
    end
    tick("restart_tens");
    chk("restart_tens_lit", 12'(dig_en_n), 12'(3'b101));

    for (int i = 0; i < 16 && !(m_idx == 0 && m_cnt == 3); i++) tick("seek_adv");
    chk("seek_adv_ok", 12'((m_idx == 0 && m_cnt == 3) ? 1 : 0), 12'd1);
    bcd_in = 12'h456; load = 1'b1;
    tick("load_456_adv");
    load = 1'b0;
    tick("show_456");
    chk("tens_5_lit", {seg_n, dig_en_n}, {2'b00, 7'h12, 3'b101});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_scan_driver.md
# bcd_scan_driver

Time-multiplexed three-digit seven-segment driver that sits directly downstream of the 8-bit-to-BCD converter. It captures the 12-bit packed BCD word (hundreds/tens/ones) on a load strobe and holds it. It then scans the three digits onto one shared active-low segment bus with one-hot active-low digit enables. Digits above 9 are flagged and shown as a dash.

## Interface
- PRESCALE, 50000, clock cycles each digit stays enabled; legal range ≥ 2; counter width = clog2(PRESCALE)
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- bcd_in  in  12  packed BCD; [11:8] hundreds, [7:4] tens, [3:0] ones
- load  in  1  when high at a clock edge, bcd_in is captured into the held register
- seg_n  out  7  active-low segments; [0]=a … [6]=g
- dig_en_n  out  3  active-low digit enable; [0] ones, [1] tens, [2] hundreds; exactly one low outside reset
- err  out  1  high while any held nibble > 9
- frame  out  1  one-cycle pulse when a full ones→tens→hundreds scan completes

## Operation
- State: held[11:0], cnt (prescaler), idx ∈ {0 ones, 1 tens, 2 hundreds}, plus registered outputs.
- Each non-reset edge:
  - load=1: held ← bcd_in.
  - cnt ← (cnt == PRESCALE-1) ? 0 : cnt+1.
  - cnt == PRESCALE-1: idx advances 0→1→2→0. The value 3 is unreachable.
- Output registers at each edge, computed from pre-edge idx/held:
  - dig_en_n ← ~(1 << idx).
  - seg_n ← pattern of held nibble idx.
  - err ← any held nibble > 9.
  - frame ← (cnt == PRESCALE-1 && idx == 2).
- Active-low patterns, written g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - nibble 10–15 → dash 0111111
- Load is level-sampled. No handshake and no busy; load may be held high continuously, in which case held tracks bcd_in each cycle.

## Timing
- Reset (synchronous):
  - held=0, cnt=0, idx=0.
  - Outputs: seg_n=7'h7F, dig_en_n=3'b111, err=0, frame=0.
- First edge after reset deasserts: dig_en_n=3'b110, seg_n shows held ones digit ("0" = 1000000).
- Output latency: one cycle from idx/held change.
  - A load at edge N is visible on seg_n/err at edge N+1 if its digit is currently selected.
- Each digit stays enabled exactly PRESCALE cycles. A full frame is 3·PRESCALE cycles, and frame pulses once per frame.
- Load at the same edge idx advances: both update together, and the newly selected digit shows the new value at the next edge.
- Reset mid-scan, any idx/cnt: the next edge gives the reset values above. The scan restarts at ones with a full PRESCALE dwell.

## Configuration
- LEADING_ZERO_BLANK_EN defined: leading zeros are blanked.
  - Hundreds digit: seg_n=7'h7F when held hundreds = 0.
  - Tens digit: seg_n=7'h7F when held hundreds = 0 and held tens = 0.
  - Ones digit is never blanked.
  - dig_en_n still scans normally, so brightness timing is unchanged.
  - A nibble > 9 is never blanked.
- Not defined: all three digits always display their decoded pattern, including leading zeros.

## Test plan
- Reset held 3 cycles → seg_n=7F, dig_en_n=111, err=0, frame=0. After release, with PRESCALE=4: 110/1000000 for 4 cycles, then 101, then 011.
- PRESCALE=4, load 12'h123 → ones 0110000 (dig 110), tens 0100100 (dig 101), hundreds 1111001 (dig 011), 4 cycles each; frame pulses once every 12 cycles.
- Load 12'h007:
  - with LEADING_ZERO_BLANK_EN: hundreds/tens seg_n=7F, ones=1111000.
  - without: hundreds/tens=1000000.
- Load 12'h1A5 → err=1 one cycle after load; tens slot shows 0111111; load 12'h105 → err=0.
- Assert reset while idx=2, cnt=2 → next edge outputs 7F/111; after release the scan restarts at ones with a 4-cycle dwell and held=0.
- Load 12'h456 on the same edge idx advances 0→1 → next edge: dig_en_n=101, seg_n=0010010 (digit 5).
